// File: rtl/ga_sync_irq.sv
// ga_sync_irq: Gate Array sync / interrupt front end.
//
// Takes the CRTC HSYNC/VSYNC and produces the monitor sync outputs and the
// Z80 interrupt. Monitor HSYNC is the CRTC HSYNC delayed by two characters
// and clipped to four. Monitor VSYNC starts on the second HSYNC after a
// CRTC VSYNC rise and lasts four HSYNCs. The 52-line interrupt counter
// (R52) raises INT on every 52nd HSYNC and is resynchronised at the start
// of monitor VSYNC.
//
// Ports:
//   CLOCK     system clock, rising edge
//   RESET     asynchronous active-high reset
//   CLKEN     1 MHz character enable shared with the CRTC
//   HSYNC_I   CRTC HSYNC
//   VSYNC_I   CRTC VSYNC
//   MODE_REQ  video mode last written to the GA
//   INT_ACK   Z80 interrupt acknowledge, one-clock pulse
//   IRQ_CLR   GA write with bit 4 set, one-clock pulse
//   HSYNC_O   monitor HSYNC
//   VSYNC_O   monitor VSYNC
//   INT       Z80 interrupt request (level)
//   MODE      active video mode, latched at HSYNC start
//   LINE_CNT  current R52 value
module ga_sync_irq (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       HSYNC_I,
  input  logic       VSYNC_I,
  input  logic [1:0] MODE_REQ,
  input  logic       INT_ACK,
  input  logic       IRQ_CLR,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       INT,
  output logic [1:0] MODE,
  output logic [5:0] LINE_CNT
);

  typedef enum logic [1:0] {StIdle, StDelay, StActive} vstate_e;

  logic       hs_p_q, vs_p_q;
  logic [2:0] hcnt_q, hcnt_d;
  logic       hsync_q;
  logic [1:0] mode_q;
  logic [5:0] line_cnt_q, line_cnt_d, line_inc;
  logic       int_q, int_d, int_set;
  vstate_e    vstate_q;
  logic [2:0] vcnt_q;
  logic       vsync_q;

  logic hs_fall, vs_rise, resync, vs_end;

  assign hs_fall = CLKEN & ~HSYNC_I & hs_p_q;
  assign vs_rise = CLKEN & VSYNC_I & ~vs_p_q;

  // Saturating count of consecutive high HSYNC_I samples.
  assign hcnt_d = !HSYNC_I ? 3'd0 : (hcnt_q == 3'd7) ? 3'd7 : hcnt_q + 3'd1;

  // Second HSYNC fall after the VSYNC rise: monitor VSYNC starts, R52 resyncs.
  assign resync = hs_fall && (vstate_q == StDelay) && (vcnt_q == 3'd1);
  assign vs_end = (vstate_q == StActive) &&
                  ((hs_fall && (vcnt_q == 3'd3)) || (CLKEN && !VSYNC_I));

  assign line_inc = line_cnt_q + 6'd1;

  always_comb begin
    line_cnt_d = line_cnt_q;
    int_set    = 1'b0;
    if (resync) begin
      line_cnt_d = 6'd0;
      int_set    = (line_cnt_q >= 6'd32);
    end else if (hs_fall) begin
      if (line_inc == 6'd52) begin
        line_cnt_d = 6'd0;
        int_set    = 1'b1;
      end else begin
        line_cnt_d = line_inc;
      end
    end
    // Acknowledge clears bit 5 of the already-updated count.
    if (INT_ACK) line_cnt_d[5] = 1'b0;

    int_d = int_q;
    if (int_set)      int_d = 1'b1;
    else if (INT_ACK) int_d = 1'b0;

    if (IRQ_CLR) begin
      line_cnt_d = 6'd0;
      int_d      = 1'b0;
    end
  end

  // Sync sampling, HSYNC shaping and mode latch.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hs_p_q  <= 1'b0;
      vs_p_q  <= 1'b0;
      hcnt_q  <= 3'd0;
      hsync_q <= 1'b0;
      mode_q  <= 2'd0;
    end else if (CLKEN) begin
      hs_p_q  <= HSYNC_I;
      vs_p_q  <= VSYNC_I;
      hcnt_q  <= hcnt_d;
      hsync_q <= (hcnt_d >= 3'd3) && (hcnt_d <= 3'd6);
      if (hcnt_d == 3'd1) mode_q <= MODE_REQ;
    end
  end

  // R52 counter and interrupt level.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      line_cnt_q <= 6'd0;
      int_q      <= 1'b0;
    end else begin
      line_cnt_q <= line_cnt_d;
      int_q      <= int_d;
    end
  end

  // VSYNC FSM; vcnt counts HSYNC falls within DELAY and ACTIVE.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      vstate_q <= StIdle;
      vcnt_q   <= 3'd0;
      vsync_q  <= 1'b0;
    end else begin
      case (vstate_q)
        StIdle: begin
          if (vs_rise) begin
            vstate_q <= StDelay;
            vcnt_q   <= 3'd0;
          end
        end
        StDelay: begin
          if (resync) begin
            vstate_q <= StActive;
            vsync_q  <= 1'b1;
            vcnt_q   <= 3'd0;
          end else if (hs_fall) begin
            vcnt_q <= vcnt_q + 3'd1;
          end
        end
        StActive: begin
          if (vs_end) begin
            vstate_q <= StIdle;
            vsync_q  <= 1'b0;
            vcnt_q   <= 3'd0;
          end else if (hs_fall) begin
            vcnt_q <= vcnt_q + 3'd1;
          end
        end
        default: begin
          vstate_q <= StIdle;
          vsync_q  <= 1'b0;
          vcnt_q   <= 3'd0;
        end
      endcase
    end
  end

  assign HSYNC_O  = hsync_q;
  assign VSYNC_O  = vsync_q;
  assign INT      = int_q;
  assign MODE     = mode_q;
  assign LINE_CNT = line_cnt_q;

endmodule
